// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared constants and FSM state encoding for the shared adder
package adder_share_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// rtl/adder_share_arbiter_rr_arbiter.sv - combinational round-robin arbiter
// Picks the first set request at or above ptr, wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx
);

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one WIDTH-bit adder shared by N_REQ requesters, round-robin
// Defining ADDER_SHARE_STATS_EN adds the op_count / ovf_count handshake statistics ports.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry,
`ifdef ADDER_SHARE_STATS_EN
    output logic                   busy,
    output logic [15:0]            op_count,
    output logic [7:0]             ovf_count
`else
    output logic                   busy
`endif
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_carry_q, rsp_carry_d;

    logic [N_REQ-1:0]   gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [WIDTH:0]     sum_full;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sum_full = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        req_ready   = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    // Grant is withheld while reset is low so every output sits at its reset value.
                    req_ready = gnt & {N_REQ{wb_rst_ni}};
                    id_d      = gnt_idx;
                    a_d       = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_d       = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    rr_ptr_d  = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + IDW'(1);
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_sum_d   = sum_full[WIDTH-1:0];
                rsp_carry_d = sum_full[WIDTH];
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = (state_q != S_IDLE);

`ifdef ADDER_SHARE_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [7:0]  ovf_count_q, ovf_count_d;

    always_comb begin
        op_count_d  = op_count_q;
        ovf_count_d = ovf_count_q;
        if (rsp_valid_q && rsp_ready) begin
            op_count_d = op_count_q + 16'd1;
            if (rsp_carry_q && (ovf_count_q != 8'hFF)) ovf_count_d = ovf_count_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            op_count_q  <= '0;
            ovf_count_q <= '0;
        end else begin
            op_count_q  <= op_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign op_count  = op_count_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule
